// File: rtl/phase_sequencer.sv
// Traffic-light phase sequencer: owns the phase table, counts ms ticks into
// seconds, advances phases on timeout or next, and arbitrates table writes so
// the active entry only changes at a phase boundary or while stopped.
// Optional build macro: PHASE_DEFAULT_PLAN_EN preloads a four-phase plan at reset.
module phase_sequencer #(
   parameter int unsigned NPHASE        = 16,
   parameter int unsigned DUR_W         = 6,
   parameter int unsigned LIGHT_W       = 10,
   parameter int unsigned TICKS_PER_SEC = 1000,
   parameter int unsigned BLINK_TICKS   = 125
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           tick_ms,
   input  logic                           stop,
   input  logic                           next,
   input  logic [3:0]                     last_phase,
   input  logic                           cfg_req,
   input  logic [3:0]                     cfg_addr,
   input  logic [DUR_W+2*LIGHT_W:0]       cfg_wdata,
   output logic                           cfg_ack,
   output logic [3:0]                     phase,
   output logic [DUR_W-1:0]               remain,
   output logic [DUR_W-1:0]               dur,
   output logic [LIGHT_W-1:0]             lights,
   output logic                           greenman,
   output logic                           phase_start
);

   localparam int unsigned ENT_W  = 1 + DUR_W + 2*LIGHT_W;
   localparam int unsigned GM_B   = ENT_W - 1;
   localparam int unsigned DUR_HI = DUR_W + 2*LIGHT_W - 1;
   localparam int unsigned DUR_LO = 2*LIGHT_W;
   localparam int unsigned MS_W   = $clog2(TICKS_PER_SEC);
   localparam int unsigned BLK_W  = $clog2(BLINK_TICKS);

   typedef enum logic {IDLE, HOLD} arb_t;

   logic [ENT_W-1:0]  tbl [NPHASE];
   logic [MS_W-1:0]   ms_cnt;
   logic [BLK_W-1:0]  blink_cnt;
   logic              blink_sel;
   arb_t              arb;

   logic              sec;
   logic              adv;
   logic              commit;
   logic [3:0]        phase_nxt;
   logic [DUR_W-1:0]  wdur;
   logic [DUR_W-1:0]  wdur_min1;
   logic [DUR_W-1:0]  dur_new;
   logic [DUR_W-1:0]  remain_adv;

   // Current entry fields seen directly by the display logic
   assign dur      = tbl[phase][DUR_HI:DUR_LO];
   assign greenman = tbl[phase][GM_B];

   // Second pulse, advance decision, write commit and next-phase duration (with write bypass)
   always_comb begin
      sec        = tick_ms && !stop && (ms_cnt == MS_W'(TICKS_PER_SEC - 1));
      adv        = next || (sec && (remain < DUR_W'(2)));
      phase_nxt  = (phase >= last_phase) ? 4'd0 : phase + 4'd1;
      commit     = 1'b0;
      case (arb)
         IDLE:    commit = cfg_req && ((cfg_addr != phase) || stop);
         HOLD:    commit = cfg_req && (adv || stop);
         default: commit = 1'b0;
      endcase
      wdur       = cfg_wdata[DUR_HI:DUR_LO];
      wdur_min1  = (wdur == '0) ? DUR_W'(1) : wdur;
      dur_new    = (commit && (cfg_addr == phase_nxt)) ? wdur : tbl[phase_nxt][DUR_HI:DUR_LO];
      remain_adv = (dur_new == '0) ? DUR_W'(1) : dur_new;
   end

   // Table, arbitration FSM, second/blink counters and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tbl         <= '{default: '0};
`ifdef PHASE_DEFAULT_PLAN_EN
         tbl[0]      <= {1'b1, DUR_W'(15), 10'b0010110010, 10'b0010110010};
         tbl[1]      <= {1'b0, DUR_W'(4),  10'b0010010010, 10'b0010110010};
         tbl[2]      <= {1'b1, DUR_W'(15), 10'b1001000101, 10'b1001000101};
         tbl[3]      <= {1'b0, DUR_W'(4),  10'b1001000100, 10'b1001000101};
         remain      <= DUR_W'(15);
`else
         remain      <= DUR_W'(1);
`endif
         phase       <= '0;
         ms_cnt      <= '0;
         blink_cnt   <= '0;
         blink_sel   <= 1'b0;
         arb         <= IDLE;
         cfg_ack     <= 1'b0;
         lights      <= '0;
         phase_start <= 1'b0;
      end else begin
         cfg_ack     <= 1'b0;
         phase_start <= 1'b0;

         if (commit) begin
            tbl[cfg_addr] <= cfg_wdata;
            cfg_ack       <= 1'b1;
         end

         case (arb)
            IDLE:    if (cfg_req && !commit) arb <= HOLD;
            HOLD:    if (!cfg_req || commit) arb <= IDLE;
            default: arb <= IDLE;
         endcase

         if (tick_ms) begin
            if (blink_cnt == BLK_W'(BLINK_TICKS - 1)) begin
               blink_cnt <= '0;
               blink_sel <= ~blink_sel;
            end else begin
               blink_cnt <= blink_cnt + BLK_W'(1);
            end
         end

         if (adv) begin
            phase       <= phase_nxt;
            remain      <= remain_adv;
            ms_cnt      <= '0;
            phase_start <= 1'b1;
         end else begin
            if (tick_ms && !stop) ms_cnt <= sec ? '0 : ms_cnt + MS_W'(1);
            if (sec)
               remain <= remain - DUR_W'(1);
            else if (commit && (cfg_addr == phase) && (wdur < remain))
               remain <= wdur_min1;
         end

         lights <= blink_sel ? tbl[phase][2*LIGHT_W-1:LIGHT_W] : tbl[phase][LIGHT_W-1:0];
      end
   end

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: scoreboard queues of expected phase
// entries and write acks, filled when stimulus is driven, drained as the DUT pulses.
module tb_phase_sequencer;

   localparam int unsigned TPS = 10;
   localparam int unsigned BLK = 5;

`ifdef PHASE_DEFAULT_PLAN_EN
   localparam logic [5:0] R0 = 6'd15;
   localparam logic [5:0] D0 = 6'd15;
   localparam logic       G0 = 1'b1;
`else
   localparam logic [5:0] R0 = 6'd1;
   localparam logic [5:0] D0 = 6'd0;
   localparam logic       G0 = 1'b0;
`endif

   typedef struct {
      logic [3:0] ph;
      logic [5:0] rem;
      int         tick;
   } adv_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        tick_ms;
   logic        stop;
   logic        next;
   logic [3:0]  last_phase;
   logic        cfg_req;
   logic [3:0]  cfg_addr;
   logic [26:0] cfg_wdata;
   logic        cfg_ack;
   logic [3:0]  phase;
   logic [5:0]  remain;
   logic [5:0]  dur;
   logic [9:0]  lights;
   logic        greenman;
   logic        phase_start;

   int   n_checks = 0;
   int   n_errors = 0;
   int   tick_count = 0;
   adv_t adv_q[$];
   int   ack_q[$];

   phase_sequencer #(
      .NPHASE(16), .DUR_W(6), .LIGHT_W(10), .TICKS_PER_SEC(TPS), .BLINK_TICKS(BLK)
   ) dut (
      .clk(clk), .rst_n(rst_n), .tick_ms(tick_ms), .stop(stop), .next(next),
      .last_phase(last_phase), .cfg_req(cfg_req), .cfg_addr(cfg_addr),
      .cfg_wdata(cfg_wdata), .cfg_ack(cfg_ack), .phase(phase), .remain(remain),
      .dur(dur), .lights(lights), .greenman(greenman), .phase_start(phase_start)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [26:0] ent(input logic gm, input logic [5:0] d,
                                       input logic [9:0] b, input logic [9:0] a);
      return {gm, d, b, a};
   endfunction

   function automatic adv_t mk(input logic [3:0] p, input logic [5:0] r, input int t);
      adv_t e;
      e.ph = p; e.rem = r; e.tick = t;
      return e;
   endfunction

   // One clock step; drains the scoreboards on phase_start / cfg_ack
   task automatic cyc();
      adv_t e;
      int   t;
      @(posedge clk);
      #1;
      if (phase_start === 1'b1) begin
         if (adv_q.size() == 0) check("adv_unexpected", 32'(phase_start), 32'd0);
         else begin
            e = adv_q.pop_front();
            check("adv_phase",  32'(phase),      32'(e.ph));
            check("adv_remain", 32'(remain),     32'(e.rem));
            check("adv_tick",   32'(tick_count), 32'(e.tick));
         end
      end
      if (cfg_ack === 1'b1) begin
         cfg_req = 1'b0;
         if (ack_q.size() == 0) check("ack_unexpected", 32'(cfg_ack), 32'd0);
         else begin
            t = ack_q.pop_front();
            check("ack_tick", 32'(tick_count), 32'(t));
         end
      end
   endtask

   task automatic do_ticks(input int n);
      repeat (n) begin
         tick_ms = 1'b1;
         tick_count++;
         cyc();
         tick_ms = 1'b0;
         cyc();
      end
   endtask

   // Write expected to be acked on the first clock
   task automatic cfg_write(input logic [3:0] a, input logic [26:0] d);
      int n;
      ack_q.push_back(tick_count);
      cfg_addr  = a;
      cfg_wdata = d;
      cfg_req   = 1'b1;
      n = 0;
      while (ack_q.size() != 0 && n < 8) begin
         cyc();
         n++;
      end
      check("ack_latency", 32'(n), 32'd1);
      if (ack_q.size() != 0) begin
         ack_q.delete();
         cfg_req = 1'b0;
      end
   endtask

   initial begin
      logic [9:0] exp_l;
      rst_n = 1'b0; tick_ms = 1'b0; stop = 1'b1; next = 1'b0;
      last_phase = 4'd0; cfg_req = 1'b0; cfg_addr = 4'd0; cfg_wdata = '0;
      cyc(); cyc();

      check("rst_phase",    32'(phase),       32'd0);
      check("rst_remain",   32'(remain),      32'(R0));
      check("rst_lights",   32'(lights),      32'd0);
      check("rst_ack",      32'(cfg_ack),     32'd0);
      check("rst_start",    32'(phase_start), 32'd0);
      check("rst_dur",      32'(dur),         32'(D0));
      check("rst_greenman", 32'(greenman),    32'(G0));
      rst_n = 1'b1;
      cyc();

      // Load a 3-phase plan while stopped, then restart phase 0 cleanly
      cfg_write(4'd0, ent(1'b0, 6'd3, 10'h155, 10'h0AA));
      cfg_write(4'd1, ent(1'b1, 6'd2, 10'h0F0, 10'h00F));
      cfg_write(4'd2, ent(1'b0, 6'd1, 10'h300, 10'h0C0));
      adv_q.push_back(mk(4'd0, 6'd3, tick_count));
      next = 1'b1; cyc(); next = 1'b0;
      cyc();
      check("p0_lights_a", 32'(lights), 32'h0AA);

      // Free-running sequence 0->1->2->0 at ticks 30, 50, 60
      last_phase = 4'd2;
      stop = 1'b0;
      adv_q.push_back(mk(4'd1, 6'd2, 30));
      adv_q.push_back(mk(4'd2, 6'd1, 50));
      adv_q.push_back(mk(4'd0, 6'd3, 60));
      do_ticks(60);
      check("seq_drained", 32'(adv_q.size()), 32'd0);

      // Stop freezes remain; next still advances
      do_ticks(10);
      check("remain_2", 32'(remain), 32'd2);
      stop = 1'b1;
      repeat (4) begin
         do_ticks(25);
         check("stop_hold", 32'(remain), 32'd2);
      end
      adv_q.push_back(mk(4'd1, 6'd2, tick_count));
      next = 1'b1; cyc(); next = 1'b0;
      check("next_phase",  32'(phase),  32'd1);
      check("next_remain", 32'(remain), 32'd2);

      // next coincident with the timeout second: single advance
      stop = 1'b0;
      do_ticks(19);
      check("remain_1", 32'(remain), 32'd1);
      adv_q.push_back(mk(4'd2, 6'd1, tick_count + 1));
      tick_ms = 1'b1; next = 1'b1; tick_count++;
      cyc();
      tick_ms = 1'b0; next = 1'b0;
      cyc(); cyc();
      check("coincide_phase", 32'(phase), 32'd2);

      // Write to the running entry is held until the phase ends
      adv_q.push_back(mk(4'd0, 6'd3, tick_count + 10));
      do_ticks(10);
      check("back_to_0", 32'(phase), 32'd0);
      ack_q.push_back(tick_count + 30);
      adv_q.push_back(mk(4'd1, 6'd2, tick_count + 30));
      adv_q.push_back(mk(4'd2, 6'd1, tick_count + 50));
      adv_q.push_back(mk(4'd0, 6'd5, tick_count + 60));
      cfg_addr = 4'd0; cfg_wdata = ent(1'b0, 6'd5, 10'h2AA, 10'h155); cfg_req = 1'b1;
      do_ticks(60);
      check("hold_ack_done", 32'(ack_q.size()), 32'd0);
      check("new_dur_seen",  32'(dur), 32'd5);

      // Non-active entry is written immediately even while running
      cfg_write(4'd3, ent(1'b0, 6'd2, 10'h000, 10'h3FF));

      // Walk to phase 3 while stopped; lights flicker regardless of stop
      stop = 1'b1;
      last_phase = 4'd3;
      adv_q.push_back(mk(4'd1, 6'd2, tick_count));
      adv_q.push_back(mk(4'd2, 6'd1, tick_count));
      adv_q.push_back(mk(4'd3, 6'd2, tick_count));
      repeat (3) begin
         next = 1'b1; cyc();
      end
      next = 1'b0;
      cyc();
      check("at_phase3", 32'(phase), 32'd3);
      for (int i = 0; i < 20; i++) begin
         tick_ms = 1'b1; tick_count++; cyc();
         tick_ms = 1'b0; cyc();
         exp_l = (((tick_count / 5) % 2) == 1) ? 10'h000 : 10'h3FF;
         check("blink", 32'(lights), 32'(exp_l));
      end
      check("blink_remain", 32'(remain), 32'd2);

      // Shortening the active entry while stopped clamps remain
      cfg_write(4'd3, ent(1'b1, 6'd1, 10'h000, 10'h3FF));
      check("clamp_remain", 32'(remain),   32'd1);
      check("clamp_dur",    32'(dur),      32'd1);
      check("clamp_gm",     32'(greenman), 32'd1);

      // last_phase lowered below phase wraps to 0; zero duration runs as 1 s
      cfg_write(4'd0, ent(1'b0, 6'd0, 10'h0F0, 10'h00F));
      last_phase = 4'd1;
      adv_q.push_back(mk(4'd0, 6'd1, tick_count));
      next = 1'b1; cyc(); next = 1'b0;
      check("wrap_phase",  32'(phase),  32'd0);
      check("dur0_remain", 32'(remain), 32'd1);
      check("dur0_dur",    32'(dur),    32'd0);

      // Write to the entry being entered is bypassed into remain
      ack_q.push_back(tick_count);
      adv_q.push_back(mk(4'd1, 6'd7, tick_count));
      cfg_addr = 4'd1; cfg_wdata = ent(1'b0, 6'd7, 10'h111, 10'h222); cfg_req = 1'b1;
      next = 1'b1; cyc(); next = 1'b0;
      check("bypass_remain", 32'(remain),       32'd7);
      check("bypass_dur",    32'(dur),          32'd7);
      check("bypass_ack",    32'(ack_q.size()), 32'd0);

      // Reset during HOLD drops the request
      stop = 1'b0;
      cfg_addr = 4'd1; cfg_wdata = ent(1'b1, 6'd9, 10'h3FF, 10'h3FF); cfg_req = 1'b1;
      cyc(); cyc(); cyc();
      check("hold_no_ack", 32'(cfg_ack), 32'd0);
      rst_n = 1'b0;
      cfg_req = 1'b0;
      #1;
      check("mid_rst_phase",  32'(phase),   32'd0);
      check("mid_rst_remain", 32'(remain),  32'(R0));
      check("mid_rst_lights", 32'(lights),  32'd0);
      check("mid_rst_ack",    32'(cfg_ack), 32'd0);
      cyc();
      rst_n = 1'b1;
      repeat (5) cyc();
      check("post_rst_phase", 32'(phase), 32'd0);
      check("post_rst_dur",   32'(dur),   32'(D0));

      check("adv_q_empty", 32'(adv_q.size()), 32'd0);
      check("ack_q_empty", 32'(ack_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
